// File: rtl/observer_uart_pkg.sv
// Shared constants and FSM encoding for the observer UART transmitter.
// Defining OBSERVER_UART_PARITY_EN switches framing from 8N1 to 8E1.
package observer_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int BIT_CNT_W            = 16;
    localparam int DATA_BITS            = 8;

`ifdef OBSERVER_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef OBSERVER_UART_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/observer_uart_fifo.sv
// Count-based byte FIFO feeding the UART transmitter; the ready flag is registered
// so the producer handshake has no combinational path through the FIFO.
module observer_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // Gating with our own flags keeps queued data safe even if a caller ignores them.
    assign do_push    = i_push && o_ready;
    assign do_pop     = i_pop && (count != '0);
    assign o_empty    = (count == '0);
    assign o_pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_ready <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            o_ready <= (count_next != FULL_COUNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/observer_uart_tx.sv
// Buffered UART transmitter: FIFO plus bit-timing FSM, 8N1 by default,
// 8E1 when OBSERVER_UART_PARITY_EN is defined.
module observer_uart_tx
    import observer_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_uart_tx
);

    localparam logic [BIT_CNT_W-1:0] BIT_RELOAD    = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           LAST_DATA_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift_reg;
    logic [7:0]           fifo_data;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 line_next;
`ifdef OBSERVER_UART_PARITY_EN
    logic                 parity_bit;
`endif

    assign push     = i_valid && o_ready;
    assign bit_done = (bit_cnt == '0);

    observer_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (i_data),
        .i_pop       (pop),
        .o_pop_data  (fifo_data),
        .o_empty     (fifo_empty),
        .o_ready     (o_ready)
    );

    // A byte leaves the FIFO when idle, or at the end of a stop bit for back-to-back frames.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == STOP && bit_done) begin
                pop = 1'b1;
            end
        end
    end

    always_comb begin
        line_next = 1'b1;
        case (state)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_reg[0];
`ifdef OBSERVER_UART_PARITY_EN
            PARITY:  line_next = parity_bit;
`endif
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef OBSERVER_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_data;
`ifdef OBSERVER_UART_PARITY_EN
                        parity_bit <= even_parity(fifo_data);
`endif
                        bit_cnt   <= BIT_RELOAD;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_RELOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == LAST_DATA_BIT) begin
                            bit_idx <= '0;
`ifdef OBSERVER_UART_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
`ifdef OBSERVER_UART_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_RELOAD;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift_reg <= fifo_data;
`ifdef OBSERVER_UART_PARITY_EN
                            parity_bit <= even_parity(fifo_data);
`endif
                            bit_cnt   <= BIT_RELOAD;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and busy lag the FSM by one register so every bit keeps its full width glitch-free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            o_uart_tx <= line_next;
            o_busy    <= !(state == IDLE && fifo_empty);
        end
    end

endmodule

// File: tb/tb_observer_uart_tx.sv
// Directed bench for observer_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; a bit-accurate
// line checker follows every frame, honouring OBSERVER_UART_PARITY_EN.
`timescale 1ns/1ps
module tb_observer_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OBSERVER_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_busy;
    logic       o_uart_tx;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] data;
        logic       exp_parity;
    } vec_t;

    vec_t vecs [6];

    observer_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_uart_tx (o_uart_tx)
    );

    always #5 i_clk = ~i_clk;

    // Line order, LSB first: start, 8 data bits, [parity], stop; bit 10 is unused in 8N1.
    function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic p);
`ifdef OBSERVER_UART_PARITY_EN
        return {1'b1, p, b, 1'b0};
`else
        return {p, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic checkValue(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; returns 1 ns after the accepting edge.
    task automatic pushByte(input logic [7:0] b);
        bit rdy;
        int tries;
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_data  = b;
        tries   = 0;
        do begin
            @(negedge i_clk);
            rdy = (o_ready === 1'b1);
            @(posedge i_clk);
            tries++;
        end while (!rdy && tries < 500);
        #1;
        i_valid = 1'b0;
        if (!rdy) begin
            checkValue("push handshake timeout", o_ready, 1'b1);
        end
    endtask

    // Caller holds i_valid high and calls this 1 ns after a rising edge.
    task automatic offerOnce(input logic [7:0] b, output bit acc);
        i_data = b;
        @(negedge i_clk);
        acc = (o_ready === 1'b1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        pushByte(v.data);
    endtask

    // mode 0: called right after an idle push (checks start latency); 1: wait for start; 2: contiguous.
    task automatic checkOutput(input logic [10:0] frame, input int mode, input bit last, input string tag);
        int  budget;
        bit  bad;
        logic seen;
        if (mode == 0) begin
            @(negedge i_clk);
            checkValue({tag, " line high on accept+1"}, o_uart_tx, 1'b1);
            @(negedge i_clk);
            checkValue({tag, " line high before 2nd edge"}, o_uart_tx, 1'b1);
            @(negedge i_clk);
        end else if (mode == 1) begin
            budget = 0;
            do begin
                @(negedge i_clk);
                budget++;
            end while (o_uart_tx !== 1'b0 && budget < 400);
            if (o_uart_tx !== 1'b0) begin
                checkValue({tag, " start bit timeout"}, o_uart_tx, 1'b0);
                return;
            end
        end else begin
            @(negedge i_clk);
        end
        for (int b = 0; b < NBITS; b++) begin
            bad  = 1'b0;
            seen = frame[b];
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge i_clk);
                if (o_uart_tx !== frame[b] && !bad) begin
                    bad  = 1'b1;
                    seen = o_uart_tx;
                end
            end
            compared++;
            if (bad) begin
                mismatched++;
                $display("[TB] FAIL %s bit %0d: line %b, expected %b", tag, b, seen, frame[b]);
            end
        end
        if (last) begin
            checkValue({tag, " busy during stop"}, o_busy, 1'b1);
            @(negedge i_clk);
            checkValue({tag, " line idle after stop"}, o_uart_tx, 1'b1);
            checkValue({tag, " busy low after stop"}, o_busy, 1'b0);
        end
    endtask

    task automatic runStreamTest();
        fork
            begin
                int idx;
                int first_block;
                int cycles;
                bit rdy;
                idx         = 0;
                first_block = -1;
                cycles      = 0;
                @(posedge i_clk);
                #1;
                i_valid = 1'b1;
                i_data  = 8'h00;
                while (idx < 6 && cycles < 2000) begin
                    @(negedge i_clk);
                    rdy = (o_ready === 1'b1);
                    if (!rdy && first_block < 0) first_block = idx;
                    @(posedge i_clk);
                    cycles++;
                    #1;
                    if (rdy) idx++;
                    i_data = 8'(idx);
                end
                i_valid = 1'b0;
                checkInt("bytes accepted before ready dropped", first_block, 5);
                checkInt("stream bytes accepted", idx, 6);
            end
            begin
                logic [7:0] kb;
                for (int k = 0; k < 6; k++) begin
                    kb = 8'(k);
                    checkOutput(makeFrame(kb, ^kb), (k == 0) ? 1 : 2, k == 5,
                                $sformatf("stream byte %0d", k));
                end
            end
        join
    endtask

    task automatic runResetTest();
        int n;
        int lows;
        pushByte(8'hA5);
        pushByte(8'h99);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_uart_tx !== 1'b0 && n < 200);
        checkValue("A5 start bit seen", o_uart_tx, 1'b0);
        repeat (4 + 3 * CPB) @(negedge i_clk);
        checkValue("A5 data bit 3 before reset", o_uart_tx, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        checkValue("line high inside reset cycle", o_uart_tx, 1'b1);
        checkValue("busy low in reset", o_busy, 1'b0);
        checkValue("ready low in reset", o_ready, 1'b0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checkValue("ready still low after release", o_ready, 1'b0);
        @(negedge i_clk);
        checkValue("ready high after first edge", o_ready, 1'b1);
        pushByte(8'h3C);
        checkOutput(makeFrame(8'h3C, 1'b0), 0, 1'b1, "post-reset 3C");
        lows = 0;
        repeat (20 * CPB) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1) lows++;
        end
        checkInt("queued byte discarded by reset", lows, 0);
    endtask

    task automatic runQueueTest();
        logic [7:0] seq [6];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
        fork
            begin
                bit acc;
                int extra;
                @(posedge i_clk);
                #1;
                i_valid = 1'b1;
                offerOnce(seq[0], acc);
                checkValue("queue X accepted", acc, 1'b1);
                offerOnce(seq[1], acc);
                checkValue("queue Y accepted", acc, 1'b1);
                offerOnce(seq[2], acc);
                checkValue("queue Z accepted", acc, 1'b1);
                i_valid = 1'b0;
                // X was popped one edge after it was queued, so Y pops 40 edges later.
                repeat (38) @(posedge i_clk);
                #1;
                i_valid = 1'b1;
                offerOnce(seq[3], acc);
                checkValue("push on pop edge accepted", acc, 1'b1);
                extra = 0;
                for (int k = 4; k < 7; k++) begin
                    offerOnce((k < 6) ? seq[k] : 8'hEE, acc);
                    if (!acc) break;
                    extra++;
                end
                i_valid = 1'b0;
                checkInt("free slots after push+pop at count 2", extra, 2);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    checkOutput(makeFrame(seq[k], ^seq[k]), (k == 0) ? 1 : 2, k == 5,
                                $sformatf("queue byte %0d", k));
                end
            end
        join
    endtask

    task automatic runQuietTest();
        int   toggles;
        int   busy_hi;
        logic prev;
        toggles = 0;
        busy_hi = 0;
        prev    = o_uart_tx;
        repeat (1000) begin
            @(negedge i_clk);
            if (o_uart_tx !== prev) toggles++;
            if (o_busy !== 1'b0) busy_hi++;
            prev = o_uart_tx;
        end
        checkInt("line toggles while idle", toggles, 0);
        checkInt("busy cycles while idle", busy_hi, 0);
        checkValue("idle line level", o_uart_tx, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'h55, exp_parity: 1'b0};
        vecs[1] = '{data: 8'h07, exp_parity: 1'b1};
        vecs[2] = '{data: 8'h03, exp_parity: 1'b0};
        vecs[3] = '{data: 8'hFF, exp_parity: 1'b0};
        vecs[4] = '{data: 8'h80, exp_parity: 1'b1};
        vecs[5] = '{data: 8'h3C, exp_parity: 1'b0};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        #12;
        checkValue("reset line", o_uart_tx, 1'b1);
        checkValue("reset ready", o_ready, 1'b0);
        checkValue("reset busy", o_busy, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checkValue("ready before first edge", o_ready, 1'b0);
        @(negedge i_clk);
        checkValue("ready after first edge", o_ready, 1'b1);

        $display("[TB] single-byte vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(makeFrame(vecs[i].data, vecs[i].exp_parity), 0, 1'b1,
                        $sformatf("vector %0d (0x%02h)", i, vecs[i].data));
        end

        $display("[TB] six-byte stream with valid held");
        runStreamTest();

        $display("[TB] reset in the middle of a frame");
        runResetTest();

        $display("[TB] push and pop on the same edge");
        runQueueTest();

        $display("[TB] idle line");
        runQuietTest();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
